// File: rtl/hash_loader.sv
`default_nettype none
// ============================================================================
//  Module      : hash_loader
//  Description : Receives a framed NTLM hash list over a UART byte stream
//                (0xA5, count N, 16*N hash bytes) into a packed target
//                register, then pulses start_bit for the cracking controller.
//                Also detects the 0x3F progress-request byte while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module hash_loader #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_HASHES     = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        data_ready,
    input  logic                        framing_error,
    input  logic                        overrun_error,
    input  logic                        busy,
    output logic [0:128*MAX_HASHES-1]   allthehashes,
    output logic [6:0]                  hash_count,
    output logic                        start_bit,
    output logic                        progress_request_byte_detected,
    output logic                        load_error
);

    localparam int VEC_W = 128 * MAX_HASHES;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] GET_COUNT = 2'd1;
    localparam logic [1:0] GET_DATA  = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam logic [7:0] PROGRESS_BYTE = 8'h3F;

    logic [1:0]       state_q,  state_d;
    logic [0:VEC_W-1] hashes_q, hashes_d;
    logic [6:0]       hcount_q, hcount_d;
    logic [6:0]       target_q, target_d;
    logic [9:0]       idx_q,    idx_d;
    logic [TO_W-1:0]  timer_q,  timer_d;
    logic             start_q,  start_d;
    logic             prog_q,   prog_d;
    logic             lerr_q,   lerr_d;

    logic             w_good;
    logic             w_bad;
    logic             w_timeout;
    logic             w_count_ok;
    logic [12:0]      w_bit_base;

    assign w_good     = data_ready & ~framing_error & ~overrun_error;
    assign w_bad      = data_ready & (framing_error | overrun_error);
    assign w_timeout  = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_count_ok = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(MAX_HASHES));
    // Byte i lands at bits [8i : 8i+7]; the first byte is the MSB of hash 0.
    assign w_bit_base = {idx_q, 3'b000};

    // Next-state logic for the load protocol, timeout supervision and pulses.
    always_comb begin
        state_d  = state_q;
        hashes_d = hashes_q;
        hcount_d = hcount_q;
        target_d = target_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        start_d  = 1'b0;
        prog_d   = 1'b0;
        lerr_d   = lerr_q;

        case (state_q)
            IDLE: begin
                // Results stay on display until the next accepted sync byte.
                if (w_good && !busy && rx_data == SYNC_BYTE) begin
                    state_d  = GET_COUNT;
                    hashes_d = '0;
                    hcount_d = '0;
                    lerr_d   = 1'b0;
                    idx_d    = '0;
                    timer_d  = '0;
                end else if (w_good && busy && rx_data == PROGRESS_BYTE) begin
                    prog_d = 1'b1;
                end
            end

            GET_COUNT: begin
                if (w_bad) begin
                    lerr_d  = 1'b1;
                    state_d = IDLE;
                end else if (w_good) begin
                    timer_d = '0;
                    if (w_count_ok) begin
                        target_d = rx_data[6:0];
                        state_d  = GET_DATA;
                    end else begin
                        lerr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (w_timeout) begin
                    lerr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end

            GET_DATA: begin
                // Sync and progress bytes are ordinary payload here.
                if (w_bad) begin
                    lerr_d  = 1'b1;
                    state_d = IDLE;
                end else if (w_good) begin
                    timer_d                  = '0;
                    hashes_d[w_bit_base +: 8] = rx_data;
                    idx_d                    = idx_q + 10'd1;
                    if (idx_q[3:0] == 4'hF) begin
                        hcount_d = hcount_q + 7'd1;
                        if (hcount_q + 7'd1 == target_q) begin
                            state_d = DONE;
                        end
                    end
                end else if (w_timeout) begin
                    lerr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end

            DONE: begin
                start_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any load silently and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hashes_q <= '0;
            hcount_q <= '0;
            target_q <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            start_q  <= 1'b0;
            prog_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hashes_q <= hashes_d;
            hcount_q <= hcount_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            start_q  <= start_d;
            prog_q   <= prog_d;
            lerr_q   <= lerr_d;
        end
    end

    assign allthehashes                   = hashes_q;
    assign hash_count                     = hcount_q;
    assign start_bit                      = start_q;
    assign progress_request_byte_detected = prog_q;
    assign load_error                     = lerr_q;

endmodule
`default_nettype wire

// File: tb/tb_hash_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hash_loader
//  Description : Randomized self-checking bench for hash_loader; the model is
//                the list of payload bytes of the current load plus expected
//                flags, compared against the packed output vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_loader;

    localparam int TO    = 50;
    localparam int MH    = 64;
    localparam int VW    = 128 * MH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'd0;
    logic          data_ready = 1'b0;
    logic          framing_error = 1'b0;
    logic          overrun_error = 1'b0;
    logic          busy = 1'b0;
    logic [0:VW-1] allthehashes;
    logic [6:0]    hash_count;
    logic          start_bit;
    logic          prog;
    logic          load_error;

    int            n_checks = 0;
    int            n_errors = 0;
    int            start_pulses = 0;
    int            prog_pulses = 0;
    logic [7:0]    exp_bytes[$];

    always #5 clk = ~clk;

    hash_loader #(
        .TIMEOUT_CYCLES (TO),
        .MAX_HASHES     (MH)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .rx_data                        (rx_data),
        .data_ready                     (data_ready),
        .framing_error                  (framing_error),
        .overrun_error                  (overrun_error),
        .busy                           (busy),
        .allthehashes                   (allthehashes),
        .hash_count                     (hash_count),
        .start_bit                      (start_bit),
        .progress_request_byte_detected (prog),
        .load_error                     (load_error)
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (start_bit === 1'b1) start_pulses++;
        if (prog === 1'b1)      prog_pulses++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Number of byte positions where the DUT vector differs from the model.
    function automatic int bad_bytes();
        int   n = 0;
        logic [7:0] e;
        for (int i = 0; i < VW / 8; i++) begin
            e = (i < exp_bytes.size()) ? exp_bytes[i] : 8'd0;
            if (allthehashes[8*i +: 8] !== e) n++;
        end
        return n;
    endfunction

    // One byte strobe; returns at the negedge after the capturing edge.
    task automatic send(input logic [7:0] b, input logic fe, input logic oe);
        @(negedge clk);
        rx_data       = b;
        data_ready    = 1'b1;
        framing_error = fe;
        overrun_error = oe;
        @(negedge clk);
        data_ready    = 1'b0;
        framing_error = 1'b0;
        overrun_error = 1'b0;
    endtask

    task automatic begin_load(input int n);
        busy = 1'b0;
        send(8'hA5, 1'b0, 1'b0);
        exp_bytes.delete();
        check("clr_vec", bad_bytes(), 0);
        check("clr_cnt", hash_count, 0);
        check("clr_err", load_error, 0);
        send(8'(n), 1'b0, 1'b0);
    endtask

    // Sends k payload bytes, checking one-cycle visibility and group count.
    task automatic send_data(input int k);
        logic [7:0] b;
        int         i;
        for (int j = 0; j < k; j++) begin
            i = exp_bytes.size();
            b = 8'($urandom_range(0, 255));
            if (i % 16 == 3) b = 8'hA5;
            if (i % 16 == 7) b = 8'h3F;
            exp_bytes.push_back(b);
            send(b, 1'b0, 1'b0);
            check("byte_lat", allthehashes[8*i +: 8], b);
            check("grp_cnt", hash_count, (i + 1) / 16);
        end
    endtask

    task automatic load_ok(input int n);
        int sp;
        begin_load(n);
        send_data(16 * n);
        sp = start_pulses;
        check("start_early", start_bit, 0);
        @(negedge clk);
        check("start_pulse", start_bit, 1);
        @(negedge clk);
        check("start_end", start_bit, 0);
        check("start_once", start_pulses - sp, 1);
        check("load_vec", bad_bytes(), 0);
        check("load_cnt", hash_count, n);
        check("load_err", load_error, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sp, pp, hc;
        logic b_busy, b_fe, e_p;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_vec", bad_bytes(), 0);
        check("rst_cnt", hash_count, 0);
        check("rst_start", start_bit, 0);
        check("rst_prog", prog, 0);
        check("rst_err", load_error, 0);

        // Three-hash load.
        load_ok(3);

        // Progress request while busy; the sync byte is ignored while busy.
        pp = prog_pulses;
        busy = 1'b1;
        send(8'h3F, 1'b0, 1'b0);
        check("prog_pulse", prog, 1);
        @(negedge clk);
        check("prog_end", prog, 0);
        send(8'hA5, 1'b0, 1'b0);
        check("busy_a5_prog", prog, 0);
        check("busy_a5_vec", bad_bytes(), 0);
        check("busy_a5_cnt", hash_count, 3);
        busy = 1'b0;
        send(8'h01, 1'b0, 1'b0);
        check("idle_hold_cnt", hash_count, 3);
        check("prog_once", prog_pulses - pp, 1);

        // Random idle traffic: only good 0x3F while busy may pulse.
        for (int r = 0; r < 24; r++) begin
            b_busy = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 2) == 0) ? 8'h3F : 8'($urandom_range(0, 255));
            if (!b_busy && b == 8'hA5) b = 8'h00;
            b_fe = ($urandom_range(0, 4) == 0);
            e_p  = b_busy && (b == 8'h3F) && !b_fe;
            busy = b_busy;
            send(b, b_fe, 1'b0);
            check("idle_prog", prog, e_p);
        end
        busy = 1'b0;
        check("idle_vec", bad_bytes(), 0);
        check("idle_cnt", hash_count, 3);

        // Count out of range, then a good single-hash load.
        begin_load(65);
        check("cnt65_err", load_error, 1);
        begin_load(0);
        check("cnt0_err", load_error, 1);
        send(8'h01, 1'b0, 1'b0);
        check("cnt0_idle", hash_count, 0);
        load_ok(1);

        // Overrun on the count byte.
        busy = 1'b0;
        send(8'hA5, 1'b0, 1'b0);
        exp_bytes.delete();
        send(8'h02, 1'b0, 1'b1);
        check("ovr_cnt_err", load_error, 1);

        // Framing error mid-load keeps the partial count, no start.
        sp = start_pulses;
        begin_load(2);
        send_data(20);
        send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        check("fe_err", load_error, 1);
        check("fe_cnt", hash_count, 1);
        repeat (5) @(negedge clk);
        check("fe_nostart", start_pulses - sp, 0);
        check("fe_vec", bad_bytes(), 0);

        // Timeout after five payload bytes.
        begin_load(1);
        send_data(5);
        repeat (TO - 1) @(negedge clk);
        check("to_early", load_error, 0);
        @(negedge clk);
        check("to_err", load_error, 1);
        check("to_cnt", hash_count, 0);

        // Reset mid-load.
        sp = start_pulses;
        begin_load(2);
        send_data(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bytes.delete();
        check("mrst_vec", bad_bytes(), 0);
        check("mrst_cnt", hash_count, 0);
        check("mrst_err", load_error, 0);
        check("mrst_start", start_bit, 0);
        repeat (4) @(negedge clk);
        check("mrst_nostart", start_pulses - sp, 0);
        load_ok(2);

        // Random sizes and the full-capacity boundary.
        for (int r = 0; r < 3; r++) begin
            load_ok($urandom_range(1, 6));
        end
        load_ok(MH);

        hc = MH;
        check("final_cnt", hash_count, hc);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
